btn_dir_ctrl: RTL and testbench

BTN_DIR_CTRL -- requirements
Module: btn_dir_ctrl

---
 rtl/btn_dir_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_btn_dir_ctrl.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/btn_dir_ctrl.sv
// btn_dir_ctrl: five-button synchronizer/debouncer feeding a snake heading controller.
// Optional pause on BtnC is enabled by defining the macro SNAKE_PAUSE_EN.
module btn_dir_ctrl #(
   parameter int unsigned DEBOUNCE_CYCLES = 250000,
   parameter int unsigned CNT_W           = 18
) (
   input  logic       ClkPort,
   input  logic       reset_n,
   input  logic       BtnU,
   input  logic       BtnR,
   input  logic       BtnD,
   input  logic       BtnL,
   input  logic       BtnC,
   input  logic       game_tick,
   output logic [1:0] dir,
   output logic       dir_changed,
   output logic [4:0] btn_pulse,
   output logic       paused,
   output logic       start_pulse
);

   localparam logic [1:0]       DIR_UP    = 2'b00;
   localparam logic [1:0]       DIR_RIGHT = 2'b01;
   localparam logic [1:0]       DIR_DOWN  = 2'b10;
   localparam logic [1:0]       DIR_LEFT  = 2'b11;
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [4:0]       raw_s;
   logic [4:0]       sync1_q;
   logic [4:0]       sync2_q;
   logic [4:0]       clean_q;
   logic [4:0]       clean_d;
   logic [4:0]       clean_prev_q;
   logic [4:0]       pulse_q;
   logic [CNT_W-1:0] cnt_q [5];
   logic [CNT_W-1:0] cnt_d [5];

   logic [1:0] dir_q;
   logic [1:0] dir_d;
   logic [1:0] pend_dir_q;
   logic [1:0] pend_dir_d;
   logic       pend_valid_q;
   logic       pend_valid_d;
   logic       dir_changed_q;
   logic       dir_changed_d;
   logic       start_q;
   logic       press_s;
   logic [1:0] press_dir_s;
   logic       commit_s;
   logic       paused_s;

   assign raw_s = {BtnC, BtnL, BtnD, BtnR, BtnU};

   // Debounce: count while the synced level disagrees with the clean level, flip on the last count.
   always_comb begin
      clean_d = clean_q;
      for (int i = 0; i < 5; i++) begin
         cnt_d[i] = '0;
         if (sync2_q[i] != clean_q[i]) begin
            if (cnt_q[i] == CNT_LAST) begin
               clean_d[i] = ~clean_q[i];
               cnt_d[i]   = '0;
            end else begin
               cnt_d[i]   = cnt_q[i] + CNT_W'(1);
            end
         end else begin
            cnt_d[i] = '0;
         end
      end
   end

   // Synchronizers, debounce counters, clean levels and rising-edge press pulses.
   always_ff @(posedge ClkPort or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q      <= 5'b00000;
         sync2_q      <= 5'b00000;
         clean_q      <= 5'b00000;
         clean_prev_q <= 5'b00000;
         pulse_q      <= 5'b00000;
         for (int i = 0; i < 5; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         sync1_q      <= raw_s;
         sync2_q      <= sync1_q;
         clean_q      <= clean_d;
         clean_prev_q <= clean_q;
         pulse_q      <= clean_q & ~clean_prev_q;
         for (int i = 0; i < 5; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   // Fixed-priority pick among simultaneous direction presses: U > R > D > L.
   always_comb begin
      press_s     = 1'b1;
      press_dir_s = DIR_UP;
      if (pulse_q[0]) begin
         press_dir_s = DIR_UP;
      end else if (pulse_q[1]) begin
         press_dir_s = DIR_RIGHT;
      end else if (pulse_q[2]) begin
         press_dir_s = DIR_DOWN;
      end else if (pulse_q[3]) begin
         press_dir_s = DIR_LEFT;
      end else begin
         press_s     = 1'b0;
      end
   end

   assign commit_s = game_tick & ~paused_s & pend_valid_q;

   // Commit the old pending heading on a tick; a same-cycle press is judged against the pre-commit heading.
   always_comb begin
      dir_d         = dir_q;
      pend_dir_d    = pend_dir_q;
      pend_valid_d  = pend_valid_q;
      dir_changed_d = 1'b0;
      if (commit_s) begin
         dir_d         = pend_dir_q;
         pend_valid_d  = 1'b0;
         dir_changed_d = (pend_dir_q != dir_q);
      end else begin
         dir_d         = dir_q;
      end
      if (press_s && (press_dir_s != (dir_q ^ 2'b10))) begin
         pend_dir_d   = press_dir_s;
         pend_valid_d = 1'b1;
      end else begin
         pend_dir_d   = pend_dir_d;
      end
   end

   // Heading, pending request and one-cycle status pulses.
   always_ff @(posedge ClkPort or negedge reset_n) begin
      if (!reset_n) begin
         dir_q         <= DIR_RIGHT;
         pend_dir_q    <= DIR_UP;
         pend_valid_q  <= 1'b0;
         dir_changed_q <= 1'b0;
         start_q       <= 1'b0;
      end else begin
         dir_q         <= dir_d;
         pend_dir_q    <= pend_dir_d;
         pend_valid_q  <= pend_valid_d;
         dir_changed_q <= dir_changed_d;
         start_q       <= pulse_q[4];
      end
   end

`ifdef SNAKE_PAUSE_EN
   logic paused_q;
   logic paused_d;

   // Each debounced BtnC press toggles pause.
   always_comb begin
      paused_d = paused_q ^ pulse_q[4];
   end

   // Pause level register.
   always_ff @(posedge ClkPort or negedge reset_n) begin
      if (!reset_n) begin
         paused_q <= 1'b0;
      end else begin
         paused_q <= paused_d;
      end
   end

   assign paused_s = paused_q;
`else
   assign paused_s = 1'b0;
`endif

   assign dir         = dir_q;
   assign dir_changed = dir_changed_q;
   assign btn_pulse   = pulse_q;
   assign paused      = paused_s;
   assign start_pulse = start_q;

endmodule

// File: tb/tb_btn_dir_ctrl.sv
// Self-checking bench for btn_dir_ctrl with a short debounce interval and a window-based reference model.
module tb_btn_dir_ctrl;

   localparam int D = 4;
   localparam logic [10:0] RST_V = 11'b00000_01_0_0_0;

   logic       ClkPort;
   logic       reset_n;
   logic       BtnU, BtnR, BtnD, BtnL, BtnC;
   logic       game_tick;
   logic [1:0] dir;
   logic       dir_changed;
   logic [4:0] btn_pulse;
   logic       paused;
   logic       start_pulse;

   int checks   = 0;
   int failures = 0;

   btn_dir_ctrl #(.DEBOUNCE_CYCLES(D), .CNT_W(3)) dut (
      .ClkPort(ClkPort), .reset_n(reset_n),
      .BtnU(BtnU), .BtnR(BtnR), .BtnD(BtnD), .BtnL(BtnL), .BtnC(BtnC),
      .game_tick(game_tick), .dir(dir), .dir_changed(dir_changed),
      .btn_pulse(btn_pulse), .paused(paused), .start_pulse(start_pulse)
   );

   initial ClkPort = 1'b0;
   always #5 ClkPort = ~ClkPort;

   // Reference model: a button is accepted once the last D synchronized samples all disagree with its clean level.
   logic [D:0] m_hist [5];
   logic [4:0] m_clean, m_rise, m_pulse;
   logic [1:0] m_dir, m_pend;
   logic       m_pv, m_dchg, m_start, m_paused;

   initial begin : model
      logic [4:0] raw;
      logic [1:0] want;
      logic       have;
      logic [1:0] old_dir;
      for (int b = 0; b < 5; b++) m_hist[b] = '0;
      m_clean = '0; m_rise = '0; m_pulse = '0;
      m_dir = 2'b01; m_pend = 2'b00; m_pv = 1'b0; m_dchg = 1'b0; m_start = 1'b0; m_paused = 1'b0;
      forever begin
         @(posedge ClkPort or negedge reset_n);
         if (!reset_n) begin
            for (int b = 0; b < 5; b++) m_hist[b] = '0;
            m_clean = '0; m_rise = '0; m_pulse = '0;
            m_dir = 2'b01; m_pend = 2'b00; m_pv = 1'b0; m_dchg = 1'b0; m_start = 1'b0; m_paused = 1'b0;
         end else begin
            raw     = {BtnC, BtnL, BtnD, BtnR, BtnU};
            old_dir = m_dir;
            m_dchg  = 1'b0;
            if (game_tick && !m_paused && m_pv) begin
               m_dchg = (m_pend != m_dir);
               m_dir  = m_pend;
               m_pv   = 1'b0;
            end
            have = 1'b1;
            want = 2'b00;
            if (m_pulse[0]) want = 2'b00;
            else if (m_pulse[1]) want = 2'b01;
            else if (m_pulse[2]) want = 2'b10;
            else if (m_pulse[3]) want = 2'b11;
            else have = 1'b0;
            if (have && (want != (old_dir ^ 2'b10))) begin
               m_pend = want;
               m_pv   = 1'b1;
            end
            m_start = m_pulse[4];
`ifdef SNAKE_PAUSE_EN
            if (m_pulse[4]) m_paused = !m_paused;
`endif
            m_pulse = m_rise;
            for (int b = 0; b < 5; b++) begin
               m_rise[b] = 1'b0;
               if (m_hist[b][D:1] == {D{~m_clean[b]}}) begin
                  m_rise[b]  = ~m_clean[b];
                  m_clean[b] = ~m_clean[b];
               end
               m_hist[b] = {m_hist[b][D-1:0], raw[b]};
            end
         end
      end
   end

   wire [10:0] obs_w = {btn_pulse, dir, dir_changed, paused, start_pulse};
   wire [10:0] exp_w = {m_pulse, m_dir, m_dchg, m_paused, m_start};

   task automatic set_btn(input logic [4:0] v);
      {BtnC, BtnL, BtnD, BtnR, BtnU} = v;
   endtask

   task automatic do_reset();
      @(negedge ClkPort);
      reset_n = 1'b0; game_tick = 1'b0; set_btn(5'b00000);
      repeat (2) @(negedge ClkPort);
      reset_n = 1'b1;
   endtask

   // Stimulus only: hold v for 'hold' cycles, then idle; reports model disagreements and pulse counts.
   task automatic press(input logic [4:0] v, input int hold, input int rest,
                        output int mism, output int npulse, output int nstart);
      mism = 0; npulse = 0; nstart = 0;
      set_btn(v);
      for (int i = 0; i < hold + rest; i++) begin
         @(negedge ClkPort);
         if (obs_w !== exp_w) mism++;
         if (btn_pulse != 5'b00000) npulse++;
         if (start_pulse) nstart++;
         if (i == hold - 1) set_btn(5'b00000);
      end
   endtask

   task automatic tick_once();
      game_tick = 1'b1;
      @(negedge ClkPort);
      game_tick = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0; game_tick = 1'b0; set_btn(5'b00001);
      repeat (3) @(negedge ClkPort);
      checks++;
      if (obs_w !== RST_V) begin failures++; $display("FAIL reset_values got=%b want=%b", obs_w, RST_V); end
      reset_n = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         @(negedge ClkPort);
         checks++;
         if (btn_pulse !== ((i == 7) ? 5'b00001 : 5'b00000)) begin
            failures++; $display("FAIL held_through_reset cyc=%0d got=%b want=%b", i, btn_pulse, (i == 7) ? 5'b00001 : 5'b00000);
         end
      end
      set_btn(5'b00000);
   endtask

   task automatic test_press_latency();
      int mism, np, ns;
      do_reset();
      @(negedge ClkPort);
      set_btn(5'b00001);
      for (int i = 1; i <= 20; i++) begin
         @(negedge ClkPort);
         checks++;
         if (btn_pulse !== ((i == 7) ? 5'b00001 : 5'b00000)) begin
            failures++; $display("FAIL press_latency cyc=%0d got=%b want=%b", i, btn_pulse, (i == 7) ? 5'b00001 : 5'b00000);
         end
      end
      press(5'b00000, 1, 9, mism, np, ns);
      checks++;
      if (mism !== 0 || np !== 0) begin failures++; $display("FAIL release_no_pulse mism=%0d pulses=%0d want 0/0", mism, np); end
      tick_once();
      checks++;
      if (dir !== 2'b00 || dir_changed !== 1'b1) begin
         failures++; $display("FAIL commit_up got dir=%b chg=%b want dir=00 chg=1", dir, dir_changed);
      end
      @(negedge ClkPort);
      checks++;
      if (dir_changed !== 1'b0) begin failures++; $display("FAIL dir_changed_width got=%b want=0", dir_changed); end
   endtask

   task automatic test_opposite();
      int mism, np, ns;
      do_reset();
      press(5'b01000, 10, 10, mism, np, ns);
      checks++;
      if (mism !== 0 || np !== 1) begin failures++; $display("FAIL opposite_press mism=%0d pulses=%0d want 0/1", mism, np); end
      tick_once();
      checks++;
      if (dir !== 2'b01 || dir_changed !== 1'b0) begin
         failures++; $display("FAIL opposite_discard got dir=%b chg=%b want dir=01 chg=0", dir, dir_changed);
      end
   endtask

   task automatic test_glitch();
      logic [10:0] pat;
      int np;
      do_reset();
      pat = 11'b11101110000;
      np  = 0;
      for (int i = 10; i >= 0; i--) begin
         set_btn({4'b0000, pat[i]});
         @(negedge ClkPort);
         checks++;
         if (btn_pulse !== 5'b00000 || obs_w !== exp_w) begin
            failures++; $display("FAIL glitch_reject step=%0d got=%b want=%b", i, obs_w, exp_w);
         end
      end
      repeat (6) begin
         @(negedge ClkPort);
         if (btn_pulse != 5'b00000) np++;
      end
      set_btn(5'b00001);
      repeat (14) begin
         @(negedge ClkPort);
         if (btn_pulse != 5'b00000) np++;
      end
      set_btn(5'b00000);
      checks++;
      if (np !== 1) begin failures++; $display("FAIL glitch_then_hold pulses=%0d want=1", np); end
   endtask

   task automatic test_simultaneous();
      int mism, np, ns;
      do_reset();
      press(5'b01100, 10, 10, mism, np, ns);
      checks++;
      if (mism !== 0) begin failures++; $display("FAIL simultaneous_model mism=%0d want=0", mism); end
      tick_once();
      checks++;
      if (dir !== 2'b10 || dir_changed !== 1'b1) begin
         failures++; $display("FAIL simultaneous_commit got dir=%b chg=%b want dir=10 chg=1", dir, dir_changed);
      end
   endtask

   task automatic test_same_cycle();
      int mism, np, ns;
      do_reset();
      press(5'b00001, 10, 10, mism, np, ns);
      set_btn(5'b01000);
      for (int i = 1; i <= 12; i++) begin
         @(negedge ClkPort);
         if (i == 7) game_tick = 1'b1;
         if (i == 8) begin
            game_tick = 1'b0;
            checks++;
            if (dir !== 2'b00 || dir_changed !== 1'b1) begin
               failures++; $display("FAIL tick_with_press got dir=%b chg=%b want dir=00 chg=1", dir, dir_changed);
            end
         end
      end
      set_btn(5'b00000);
      repeat (8) @(negedge ClkPort);
      tick_once();
      checks++;
      if (dir !== 2'b00 || dir_changed !== 1'b0) begin
         failures++; $display("FAIL precommit_opposite got dir=%b chg=%b want dir=00 chg=0", dir, dir_changed);
      end
      do_reset();
      press(5'b00010, 10, 10, mism, np, ns);
      tick_once();
      checks++;
      if (dir !== 2'b01 || dir_changed !== 1'b0 || obs_w !== exp_w) begin
         failures++; $display("FAIL same_dir_commit got dir=%b chg=%b want dir=01 chg=0", dir, dir_changed);
      end
   endtask

   task automatic test_pause();
      int mism, np, ns;
      do_reset();
      press(5'b10000, 10, 10, mism, np, ns);
      checks++;
      if (mism !== 0 || ns !== 1) begin failures++; $display("FAIL start_pulse mism=%0d starts=%0d want 0/1", mism, ns); end
`ifdef SNAKE_PAUSE_EN
      checks++;
      if (paused !== 1'b1) begin failures++; $display("FAIL pause_on got=%b want=1", paused); end
      press(5'b00100, 10, 10, mism, np, ns);
      tick_once();
      checks++;
      if (dir !== 2'b01 || dir_changed !== 1'b0) begin
         failures++; $display("FAIL paused_tick got dir=%b chg=%b want dir=01 chg=0", dir, dir_changed);
      end
      press(5'b10000, 10, 10, mism, np, ns);
      checks++;
      if (paused !== 1'b0) begin failures++; $display("FAIL pause_off got=%b want=0", paused); end
`else
      checks++;
      if (paused !== 1'b0) begin failures++; $display("FAIL pause_tied got=%b want=0", paused); end
      press(5'b00100, 10, 10, mism, np, ns);
`endif
      tick_once();
      checks++;
      if (dir !== 2'b10 || dir_changed !== 1'b1) begin
         failures++; $display("FAIL resume_commit got dir=%b chg=%b want dir=10 chg=1", dir, dir_changed);
      end
   endtask

   task automatic test_reset_mid();
      int np;
      do_reset();
      set_btn(5'b00001);
      repeat (10) @(negedge ClkPort);
      set_btn(5'b00100);
      repeat (4) @(negedge ClkPort);
      reset_n = 1'b0;
      #1;
      checks++;
      if (obs_w !== RST_V) begin failures++; $display("FAIL async_reset got=%b want=%b", obs_w, RST_V); end
      set_btn(5'b00000);
      @(negedge ClkPort);
      reset_n = 1'b1;
      np = 0;
      for (int i = 0; i < 16; i++) begin
         game_tick = (i % 4 == 1);
         @(negedge ClkPort);
         if (btn_pulse != 5'b00000 || dir !== 2'b01 || dir_changed !== 1'b0) np++;
      end
      game_tick = 1'b0;
      checks++;
      if (np !== 0) begin failures++; $display("FAIL reset_discard bad_cycles=%0d want=0", np); end
   endtask

   task automatic test_random();
      int hold [5];
      logic [4:0] lvl;
      int bad;
      do_reset();
      lvl = 5'b00000;
      bad = 0;
      for (int b = 0; b < 5; b++) hold[b] = 0;
      for (int c = 0; c < 3000; c++) begin
         @(negedge ClkPort);
         checks++;
         if (obs_w !== exp_w) begin
            failures++;
            if (bad < 10) $display("FAIL random_model cyc=%0d got=%b want=%b", c, obs_w, exp_w);
            bad++;
         end
         for (int b = 0; b < 5; b++) begin
            if (hold[b] == 0) begin
               lvl[b]  = ($urandom_range(0, 2) == 0) ? ~lvl[b] : lvl[b];
               hold[b] = $urandom_range(1, 10);
            end else begin
               hold[b] = hold[b] - 1;
            end
         end
         set_btn(lvl);
         game_tick = ($urandom_range(0, 5) == 0);
      end
      game_tick = 1'b0;
      set_btn(5'b00000);
   endtask

   initial begin
      reset_n = 1'b0; game_tick = 1'b0; set_btn(5'b00000);
      test_reset();
      test_press_latency();
      test_opposite();
      test_glitch();
      test_simultaneous();
      test_same_cycle();
      test_pause();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
